// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding, majority vote.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRK_WAIT
  } rx_state_t;

  // Majority of three samples
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk tick every i_div+1 clks while enabled.
module uart_baud_tick #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick_c
);

  logic [DIV_W-1:0] r_cnt;

  assign o_tick_c = i_en && (r_cnt == i_div);

  // Divisor counter, held at zero while disabled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (!i_en || o_tick_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority-vote sampling, parity/framing/break
// detection and a single-entry valid/ready holding register.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned DIV_W        = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    rx_en,
  input  logic [DIV_W-1:0]        baud_div,
  input  logic [1:0]              parity_mode,
  output logic [PAYLOAD_BITS-1:0] rx_data,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic                    rx_perr,
  output logic                    rx_ferr,
  output logic                    rx_break,
  output logic                    rx_overrun
);

  localparam int unsigned M  = OVERSAMPLE / 2;
  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

  logic                    r_sync1, r_sync2;
  rx_state_t               r_state;
  logic [DIV_W-1:0]        r_div;
  logic [1:0]              r_par;
  logic [TW-1:0]           r_tick_cnt;
  logic [BW-1:0]           r_bit_cnt;
  logic                    r_stop_cnt;
  logic                    r_s0, r_s1;
  logic [PAYLOAD_BITS-1:0] r_shift;
  logic                    r_perr, r_ferr, r_par_bit;

  logic [PAYLOAD_BITS-1:0] r_rx_data;
  logic                    r_rx_valid, r_rx_perr, r_rx_ferr, r_rx_break, r_rx_overrun;

  logic w_s_rxd, w_tick, w_maj, w_mid, w_end, w_par_en, w_last_stop;
  logic w_done, w_ferr_fin, w_brk;

  assign w_s_rxd     = r_sync2;
  assign w_maj       = maj3(r_s0, r_s1, w_s_rxd);
  assign w_mid       = w_tick && (r_tick_cnt == TW'(M + 1));
  assign w_end       = w_tick && (r_tick_cnt == TW'(OVERSAMPLE - 1));
  assign w_par_en    = (r_par == PAR_EVEN) || (r_par == PAR_ODD);
  assign w_last_stop = (r_stop_cnt == 1'(STOP_BITS - 1));
  assign w_done      = rx_en && (r_state == ST_STOP) && w_mid && w_last_stop;
  assign w_ferr_fin  = r_ferr | ~w_maj;
  assign w_brk       = (r_shift == '0) && (!w_par_en || !r_par_bit) && w_ferr_fin;

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign rx_perr    = r_rx_perr;
  assign rx_ferr    = r_rx_ferr;
  assign rx_break   = r_rx_break;
  assign rx_overrun = r_rx_overrun;

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk      (clk),
    .resetn   (resetn),
    .i_en     (r_state != ST_IDLE),
    .i_div    (r_div),
    .o_tick_c (w_tick)
  );

  // Two-flop synchroniser, idles high
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rxd;
      r_sync2 <= r_sync1;
    end
  end

  // Frame FSM with tick/bit counters and majority sampling
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_div      <= '0;
      r_par      <= PAR_NONE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_s0       <= 1'b0;
      r_s1       <= 1'b0;
      r_shift    <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_par_bit  <= 1'b0;
    end else begin
      if (w_tick) begin
        r_tick_cnt <= (r_tick_cnt == TW'(OVERSAMPLE - 1)) ? '0 : r_tick_cnt + TW'(1);
        if (r_tick_cnt == TW'(M - 1)) r_s0 <= w_s_rxd;
        if (r_tick_cnt == TW'(M))     r_s1 <= w_s_rxd;
      end
      if (!rx_en || (r_state == ST_IDLE)) begin
        r_tick_cnt <= '0;
        r_bit_cnt  <= '0;
        r_stop_cnt <= 1'b0;
        r_perr     <= 1'b0;
        r_ferr     <= 1'b0;
        r_par_bit  <= 1'b0;
      end
      if (!rx_en) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (!w_s_rxd) begin
              r_state <= ST_START;
              r_div   <= baud_div;
              r_par   <= parity_mode;
            end
          end
          ST_START: begin
            if (w_mid && w_maj) r_state <= ST_IDLE;
            else if (w_end)     r_state <= ST_DATA;
          end
          ST_DATA: begin
            if (w_mid) r_shift[r_bit_cnt] <= w_maj;
            if (w_end) begin
              if (r_bit_cnt == BW'(PAYLOAD_BITS - 1)) begin
                r_bit_cnt <= '0;
                r_state   <= w_par_en ? ST_PARITY : ST_STOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + BW'(1);
              end
            end
          end
          ST_PARITY: begin
            if (w_mid) begin
              r_par_bit <= w_maj;
              r_perr    <= w_maj ^ ((r_par == PAR_EVEN) ? ^r_shift : ~^r_shift);
            end
            if (w_end) r_state <= ST_STOP;
          end
          ST_STOP: begin
            if (w_mid) begin
              if (!w_maj) r_ferr <= 1'b1;
              if (w_last_stop) r_state <= w_brk ? ST_BRK_WAIT : ST_IDLE;
            end
            if (w_end) r_stop_cnt <= r_stop_cnt + 1'b1;
          end
          ST_BRK_WAIT: begin
            if (w_s_rxd) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Holding register with valid/ready handshake and overrun pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_perr    <= 1'b0;
      r_rx_ferr    <= 1'b0;
      r_rx_break   <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      r_rx_overrun <= 1'b0;
      if (w_done) begin
        if (!r_rx_valid || rx_ready) begin
          r_rx_valid <= 1'b1;
          r_rx_data  <= r_shift;
          r_rx_perr  <= r_perr;
          r_rx_ferr  <= w_ferr_fin;
          r_rx_break <= w_brk;
        end else begin
          r_rx_overrun <= 1'b1;
        end
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Second-generation UART receiver with 16x-style oversampling and majority-vote bit sampling. Baud divisor, parity mode and frame width are configurable. Error detection covers parity, framing, break and overrun. Received frames are presented to the fabric through a single-entry valid/ready holding register. It sits beside the existing UART transmitter in the serial I/O subsystem and replaces the fixed-rate receiver.

Parameters:
PAYLOAD_BITS, 8, data bits per frame (5..9).
STOP_BITS, 1, stop bits checked per frame (1 or 2).
OVERSAMPLE, 16, ticks per bit period (even, 8..32).
DIV_W, 16, width of the runtime baud divisor.

Ports:
clk  in  1  system clock.
resetn  in  1  reset.
uart_rxd  in  1  asynchronous serial input, idle high.
rx_en  in  1  receiver enable.
baud_div  in  DIV_W  oversample tick period minus one, in clk cycles.
parity_mode  in  2  0=none, 1=even, 2=odd, 3=none.
rx_data  out  PAYLOAD_BITS  received word, LSB first on line.
rx_valid  out  1  holding register full.
rx_ready  in  1  consumer accepts the word when rx_valid&&rx_ready.
rx_perr  out  1  parity error for the held word.
rx_ferr  out  1  framing error (a stop bit sampled 0) for the held word.
rx_break  out  1  break condition for the held word.
rx_overrun  out  1  one-cycle pulse: a frame completed while the holding register was full.

Interface note: reset resetn, asynchronous, active-low; clock clk.

Behaviour:
- Reset values: rx_data=0, rx_valid/rx_perr/rx_ferr/rx_break/rx_overrun=0; both synchroniser flops=1; FSM=IDLE; all counters=0.
- uart_rxd passes through a 2-flop synchroniser; all logic uses the synchronised value s_rxd.
- Tick generator: div counter runs only when FSM!=IDLE. Tick when count==baud_div_l, then count returns to 0. Tick period is therefore baud_div_l+1 clks.
- baud_div_l and parity mode are latched on leaving IDLE. Changes mid-frame have no effect. baud_div=0 gives a tick every clk.
- Tick counter (0..OVERSAMPLE-1) counts ticks within a bit. Samples are taken at ticks M-1, M and M+1, where M=OVERSAMPLE/2. The bit value is the majority of the three samples, evaluated on tick M+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
- IDLE: rx_en=1 and s_rxd=0 -> START. All counters are cleared on entry.
- START: majority=1 is a false start -> IDLE. Majority=0 -> wait for bit end -> DATA.
- DATA: shift the majority value into bit [bit_cnt]. After PAYLOAD_BITS bits -> PARITY if parity is enabled, else STOP.
- PARITY: perr = majority XOR (even ? ^data : ~^data).
- STOP: each stop bit is majority-sampled; any 0 sets ferr. The frame completes on tick M+1 of the last stop bit; no wait for the bit end.
- Break: data all 0, parity bit 0 (if enabled) and ferr set. On completion rx_break=1 and FSM -> BRK_WAIT. BRK_WAIT stays until s_rxd=1, then -> IDLE. A held-low line produces exactly one break frame.
- Non-break completion -> IDLE immediately.
- Completion with the holding register empty, or with rx_valid&&rx_ready in the same cycle: the next cycle gives rx_valid=1 with the new rx_data and flags.
- Completion with rx_valid=1 and rx_ready=0: the new frame is discarded, the held word is unchanged, and rx_overrun pulses for 1 clk.
- rx_valid drops the cycle after acceptance unless a completion coincides with it. rx_data and flags are stable while rx_valid=1.
- rx_en=0: FSM forced to IDLE the next clk; any partial frame is discarded without flags. The holding register and handshake continue to operate. The synchroniser keeps running.
- Latency: rx_valid rises 1 clk after the completion tick. Total ≈ 2 sync clks + (1 + PAYLOAD_BITS + parity + STOP_BITS - 1) bit periods + (M+1) ticks.
- Async reset mid-frame returns everything to the reset values; no spurious rx_valid after release.

Decomposition:
- Shared package uart_pkg holds: parity mode constants (PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2); FSM state encoding; a majority-of-3 function.
- One sub-module, uart_baud_tick (divisor counter plus enable, outputs a tick pulse), reused later by the transmitter.

Test Plan:
1. PAYLOAD_BITS=8, baud_div=3 (64 clk/bit), no parity, send 0xA5 with rx_ready=1 -> rx_data=0xA5, rx_valid for 1 clk, perr=ferr=break=0.
2. Even parity, send 0x3C with parity bit 1 -> rx_perr=1, rx_data=0x3C. Odd parity with bit 1 -> rx_perr=0.
3. Send 0x55 with a 1-tick low glitch in every bit, plus a 10-clk low pulse on the idle line -> 0x55 received intact, no extra frame.
4. Hold the line low for 30 bit periods, then high -> exactly one frame: rx_data=0x00, rx_ferr=1, rx_break=1. The next frame 0x12 is received correctly.
5. rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11 and rx_overrun pulses once. After rx_ready=1, rx_valid drops and 0x22 is not presented.
6. Drop rx_en or assert resetn=0 at the 4th data bit of 0xF0 -> no rx_valid. A following 0x0F is received correctly; after reset all outputs read 0.
